// File: rtl/stage_timeline_recorder_if.sv
// Bus bundle for stage_timeline_recorder: run control, stage flag vectors, read port and status.
// The master modport belongs to whoever drives the core status; slave is the recorder.
interface stage_timeline_recorder_if #(
  parameter int NUM_INSTR  = 8,
  parameter int NUM_STAGES = 5,
  parameter int CYC_W      = 16
);
  localparam int IW = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1;
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                            start;
  logic                            stop;
  logic [NUM_STAGES*NUM_INSTR-1:0] stage_flags;
  logic                            rd_en;
  logic [IW-1:0]                   rd_instr;
  logic [SW-1:0]                   rd_stage;
  logic                            rd_valid;
  logic [CYC_W-1:0]                rd_cycle;
  logic                            rd_captured;
  logic [CYC_W-1:0]                cycle_count;
  logic                            running;
  logic                            all_done;
  logic                            cyc_sat;
  logic                            order_err;
  logic [IW-1:0]                   order_err_instr;

  modport master (
    output start, stop, stage_flags, rd_en, rd_instr, rd_stage,
    input  rd_valid, rd_cycle, rd_captured, cycle_count, running, all_done, cyc_sat,
           order_err, order_err_instr
  );

  modport slave (
    input  start, stop, stage_flags, rd_en, rd_instr, rd_stage,
    output rd_valid, rd_cycle, rd_captured, cycle_count, running, all_done, cyc_sat,
           order_err, order_err_instr
  );
endinterface

// File: rtl/stage_timeline_recorder.sv
// Records the first cycle each (instruction, stage) flag goes high and serves it via a read port.
// Optional stage-ordering checker is built only when TIMELINE_ORDER_CHECK_EN is defined.
module stage_timeline_recorder #(
  parameter int NUM_INSTR  = 8,
  parameter int NUM_STAGES = 5,
  parameter int CYC_W      = 16
) (
  input logic                   clk,
  input logic                   reset,
  stage_timeline_recorder_if.slave bus
);

  localparam int NP = NUM_INSTR * NUM_STAGES;
  localparam int FW = (NP > 1) ? $clog2(NP) : 1;
  localparam int IW = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1;
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CYC_W-1:0] CYC_MAX = '1;
  localparam logic [IW:0]      NI_LIM  = (IW+1)'(NUM_INSTR);
  localparam logic [SW:0]      NS_LIM  = (SW+1)'(NUM_STAGES);

  logic [1:0]       state_q, state_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic             cyc_sat_q, cyc_sat_d;
  logic             all_done_q, all_done_d;

  logic [NP-1:0]    cap_q, cap_now, cap_nxt;
  logic [CYC_W-1:0] ts_q [NP];
  logic             run_cyc;
  logic             all_last;

  logic             rd_hit;
  logic [FW-1:0]    rd_idx;
  logic             rd_valid_q;
  logic             rd_captured_q;
  logic [CYC_W-1:0] rd_cycle_q;

  // Capture is suppressed in the start cycle because start wipes the table at that edge.
  assign run_cyc  = (state_q == ST_RUN) && !bus.start;
  assign cap_now  = run_cyc ? (bus.stage_flags & ~cap_q) : '0;
  assign cap_nxt  = cap_q | cap_now;
  assign all_last = &cap_nxt[NP-1 -: NUM_INSTR];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cyc_sat_d  = cyc_sat_q;
    all_done_d = all_done_q;
    if (bus.start) begin
      state_d    = ST_RUN;
      cnt_d      = '0;
      cyc_sat_d  = 1'b0;
      all_done_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (cnt_q != CYC_MAX) begin
        cnt_d = cnt_q + CYC_W'(1);
      end
      if (cnt_d == CYC_MAX) begin
        cyc_sat_d = 1'b1;
      end
      if (all_last) begin
        state_d    = ST_DONE;
        all_done_d = 1'b1;
      end else if (bus.stop) begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cyc_sat_q  <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cyc_sat_q  <= cyc_sat_d;
      all_done_q <= all_done_d;
    end
  end

  // Timeline table: one captured bit and timestamp per (stage, instr) pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q <= '0;
      for (int p = 0; p < NP; p++) begin
        ts_q[p] <= '0;
      end
    end else if (bus.start) begin
      cap_q <= '0;
      for (int p = 0; p < NP; p++) begin
        ts_q[p] <= '0;
      end
    end else begin
      cap_q <= cap_nxt;
      for (int p = 0; p < NP; p++) begin
        if (cap_now[p]) begin
          ts_q[p] <= cnt_q;
        end
      end
    end
  end

  // Read port: address decode with range check, result registered one cycle later.
  always_comb begin
    rd_hit = ({1'b0, bus.rd_instr} < NI_LIM) && ({1'b0, bus.rd_stage} < NS_LIM);
    rd_idx = '0;
    if (rd_hit) begin
      rd_idx = FW'(bus.rd_stage) * FW'(NUM_INSTR) + FW'(bus.rd_instr);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q    <= 1'b0;
      rd_captured_q <= 1'b0;
      rd_cycle_q    <= '0;
    end else begin
      rd_valid_q    <= bus.rd_en;
      rd_captured_q <= 1'b0;
      rd_cycle_q    <= '0;
      if (bus.rd_en && rd_hit && cap_q[rd_idx]) begin
        rd_captured_q <= 1'b1;
        rd_cycle_q    <= ts_q[rd_idx];
      end
    end
  end

`ifdef TIMELINE_ORDER_CHECK_EN
  logic [NUM_INSTR-1:0] viol;
  logic                 order_err_q, order_err_d;
  logic [IW-1:0]        order_instr_q, order_instr_d;

  always_comb begin
    viol = '0;
    for (int i = 0; i < NUM_INSTR; i++) begin
      for (int s = 1; s < NUM_STAGES; s++) begin
        if (cap_now[s*NUM_INSTR+i] && !cap_nxt[(s-1)*NUM_INSTR+i]) begin
          viol[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    order_err_d   = order_err_q;
    order_instr_d = order_instr_q;
    if (bus.start) begin
      order_err_d   = 1'b0;
      order_instr_d = '0;
    end else if (!order_err_q && (|viol)) begin
      order_err_d = 1'b1;
      // Descending scan so the lowest violating instruction is the one kept.
      for (int i = NUM_INSTR - 1; i >= 0; i--) begin
        if (viol[i]) begin
          order_instr_d = IW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      order_err_q   <= 1'b0;
      order_instr_q <= '0;
    end else begin
      order_err_q   <= order_err_d;
      order_instr_q <= order_instr_d;
    end
  end

  assign bus.order_err       = order_err_q;
  assign bus.order_err_instr = order_instr_q;
`else
  assign bus.order_err       = 1'b0;
  assign bus.order_err_instr = '0;
`endif

  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_captured = rd_captured_q;
  assign bus.rd_cycle    = rd_cycle_q;
  assign bus.cycle_count = cnt_q;
  assign bus.running     = (state_q == ST_RUN);
  assign bus.all_done    = all_done_q;
  assign bus.cyc_sat     = cyc_sat_q;

endmodule

// File: tb/tb_stage_timeline_recorder.sv
// Directed bench for stage_timeline_recorder: 8x5/16-bit instance plus a 4-bit counter instance.
module tb_stage_timeline_recorder;

`ifdef TIMELINE_ORDER_CHECK_EN
  localparam bit OE = 1'b1;
`else
  localparam bit OE = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  stage_timeline_recorder_if #(.NUM_INSTR(8), .NUM_STAGES(5), .CYC_W(16)) bus ();
  stage_timeline_recorder_if #(.NUM_INSTR(8), .NUM_STAGES(5), .CYC_W(4))  bus4 ();

  stage_timeline_recorder #(.NUM_INSTR(8), .NUM_STAGES(5), .CYC_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  stage_timeline_recorder #(.NUM_INSTR(8), .NUM_STAGES(5), .CYC_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int i, input int s);
    bus.rd_en    = 1'b1;
    bus.rd_instr = 3'(i);
    bus.rd_stage = 3'(s);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    clk     = 1'b0;
    reset   = 1'b1;
    bus.start = 0; bus.stop = 0; bus.stage_flags = '0; bus.rd_en = 0;
    bus.rd_instr = '0; bus.rd_stage = '0;
    bus4.start = 0; bus4.stop = 0; bus4.stage_flags = '0; bus4.rd_en = 0;
    bus4.rd_instr = '0; bus4.rd_stage = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_eq("rst_running", bus.running, 0);
    check_eq("rst_cycle", bus.cycle_count, 0);
    check_eq("rst_all_done", bus.all_done, 0);
    check_eq("rst_rd_valid", bus.rd_valid, 0);

    // Run A: capture instr 0 stage 0 at cycle 3
    bus.start = 1; tick(); bus.start = 0;
    check_eq("a_running", bus.running, 1);
    check_eq("a_cycle0", bus.cycle_count, 0);
    tick(); tick(); tick();
    check_eq("a_cycle3", bus.cycle_count, 3);
    bus.stage_flags[0] = 1'b1;
    repeat (5) tick();
    bus.stage_flags = '0;
    rd(0, 0); tick();
    check_eq("rd00_valid", bus.rd_valid, 1);
    check_eq("rd00_cycle", bus.rd_cycle, 3);
    check_eq("rd00_cap", bus.rd_captured, 1);
    rd(1, 0); tick();
    check_eq("rd10_valid", bus.rd_valid, 1);
    check_eq("rd10_cycle", bus.rd_cycle, 0);
    check_eq("rd10_cap", bus.rd_captured, 0);
    rd(0, 5); tick();
    check_eq("rd_oor_valid", bus.rd_valid, 1);
    check_eq("rd_oor_cap", bus.rd_captured, 0);
    check_eq("rd_oor_cycle", bus.rd_cycle, 0);
    bus.rd_en = 0; tick();
    check_eq("rd_idle_valid", bus.rd_valid, 0);
    check_eq("a_cycle12", bus.cycle_count, 12);

    // Instr 2 stage 2 with stage 1 never seen
    bus.stage_flags[18] = 1'b1; tick(); bus.stage_flags = '0;
    check_eq("ord_err", bus.order_err, 32'(OE));
    check_eq("ord_instr", bus.order_err_instr, OE ? 2 : 0);
    rd(2, 2); tick(); bus.rd_en = 0;
    check_eq("rd22_cycle", bus.rd_cycle, 12);
    check_eq("rd22_cap", bus.rd_captured, 1);

    // Restart: start and stop together, start wins
    bus.start = 1; bus.stop = 1; tick(); bus.start = 0; bus.stop = 0;
    check_eq("rs_running", bus.running, 1);
    check_eq("rs_cycle", bus.cycle_count, 0);
    check_eq("rs_ord_err", bus.order_err, 0);
    rd(0, 0); tick(); bus.rd_en = 0;
    check_eq("rs_rd00_cap", bus.rd_captured, 0);
    // In-order chain for instr 5 stages 0..2 in one cycle: no violation
    bus.stage_flags[5] = 1; bus.stage_flags[13] = 1; bus.stage_flags[21] = 1;
    tick(); bus.stage_flags = '0;
    check_eq("chain_no_err", bus.order_err, 0);
    rd(5, 2); tick(); bus.rd_en = 0;
    check_eq("rd52_cycle", bus.rd_cycle, 1);
    check_eq("rd52_cap", bus.rd_captured, 1);
    bus.stop = 1; tick(); bus.stop = 0;
    check_eq("stop_running", bus.running, 0);
    check_eq("stop_all_done", bus.all_done, 0);
    check_eq("stop_cycle", bus.cycle_count, 4);
    bus.stage_flags[1] = 1; tick(); tick(); bus.stage_flags = '0;
    check_eq("done_cycle_hold", bus.cycle_count, 4);
    rd(1, 0); tick(); bus.rd_en = 0;
    check_eq("done_flag_ign", bus.rd_captured, 0);

    // Completion: all last stages at cycle 10
    bus.start = 1; tick(); bus.start = 0;
    repeat (10) tick();
    bus.stage_flags = {8'hFF, 32'h0}; tick();
    check_eq("cmp_all_done", bus.all_done, 1);
    check_eq("cmp_running", bus.running, 0);
    check_eq("cmp_cycle", bus.cycle_count, 11);
    bus.stage_flags = 40'h1; tick();
    check_eq("cmp_cycle_hold", bus.cycle_count, 11);
    rd(0, 0); tick();
    check_eq("cmp_flag_ign", bus.rd_captured, 0);
    rd(3, 4); tick(); bus.rd_en = 0; bus.stage_flags = '0;
    check_eq("rd34_cycle", bus.rd_cycle, 10);
    check_eq("rd34_cap", bus.rd_captured, 1);

    // Async reset mid-run with captures present
    bus.start = 1; tick(); bus.start = 0;
    bus.stage_flags[1] = 1; tick(); bus.stage_flags = '0;
    rd(1, 0); tick(); bus.rd_en = 0;
    check_eq("pre_rst_cap", bus.rd_captured, 1);
    reset = 1; #2;
    check_eq("arst_running", bus.running, 0);
    check_eq("arst_cycle", bus.cycle_count, 0);
    check_eq("arst_rd_valid", bus.rd_valid, 0);
    check_eq("arst_rd_cap", bus.rd_captured, 0);
    reset = 0;
    tick();
    rd(1, 0); tick(); bus.rd_en = 0;
    check_eq("post_rst_valid", bus.rd_valid, 1);
    check_eq("post_rst_cap", bus.rd_captured, 0);

    // Saturation on the 4-bit counter instance
    bus4.start = 1; tick(); bus4.start = 0;
    repeat (14) tick();
    check_eq("sat_cycle14", bus4.cycle_count, 14);
    check_eq("sat_not_yet", bus4.cyc_sat, 0);
    repeat (6) tick();
    check_eq("sat_cycle15", bus4.cycle_count, 15);
    check_eq("sat_flag", bus4.cyc_sat, 1);
    bus4.stage_flags[0] = 1; tick(); bus4.stage_flags = '0;
    check_eq("sat_hold", bus4.cycle_count, 15);
    bus4.rd_en = 1; bus4.rd_instr = '0; bus4.rd_stage = '0; tick(); bus4.rd_en = 0;
    check_eq("sat_rd_cycle", bus4.rd_cycle, 15);
    check_eq("sat_rd_cap", bus4.rd_captured, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
